bcd_rtc_counter: RTL and testbench

- Running, settable real-time clock. Counts hours, minutes, seconds and hundredths in packed BCD from a clock-derived tick.
- Successor to the static time_set path. Adds a parametrised prescaler, a run/stop control, a 12/24-hour display mode, range-checked field loads, and day-wrap/error flags.
- Sits between the user switches/keys and seven_seg_driver. Its 32-bit BCD output feeds time_in_bcd directly.

---
 rtl/bcd_rtc_counter.sv | 120 ++++++++++++
 tb/tb_bcd_rtc_counter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_rtc_counter.sv
// Running BCD real-time clock: hours/minutes/seconds/hundredths advanced from a
// prescaled clk tick, with range-checked field loads and a 12/24-hour hour view.
module bcd_rtc_counter #(
    parameter int CLK_DIV = 500000,
    parameter int DIV_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode_12h,
    input  logic [7:0]  time_in,
    input  logic        set_hour,
    input  logic        set_minute,
    input  logic        set_second,
    input  logic        set_mil,
    output logic [31:0] time_bcd,
    output logic        pm,
    output logic        tick,
    output logic        day_wrap,
    output logic        set_err
);
    localparam logic [DIV_W-1:0] TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] presc;
    logic [7:0]       hour, minute, second, mil;
    logic [7:0]       hour_disp;

    logic adv;
    logic ld_hour, ld_minute, ld_second, ld_mil;
    logic c_second, c_minute, c_hour, wrap, bad_load;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_legal(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // A legally loaded field swallows the carry coming into it and emits none,
    // so the ripple chain is simply broken at every loaded field.
    always_comb begin
        adv       = run && (presc == TC);
        ld_hour   = set_hour   && bcd_legal(time_in, 8'h23);
        ld_minute = set_minute && bcd_legal(time_in, 8'h59);
        ld_second = set_second && bcd_legal(time_in, 8'h59);
        ld_mil    = set_mil    && bcd_legal(time_in, 8'h99);
        c_second  = adv      && !ld_mil    && (mil    == 8'h99);
        c_minute  = c_second && !ld_second && (second == 8'h59);
        c_hour    = c_minute && !ld_minute && (minute == 8'h59);
        wrap      = c_hour   && !ld_hour   && (hour   == 8'h23);
        bad_load  = (set_hour && !ld_hour) || (set_minute && !ld_minute) ||
                    (set_second && !ld_second) || (set_mil && !ld_mil);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            hour     <= 8'h00;
            minute   <= 8'h00;
            second   <= 8'h00;
            mil      <= 8'h00;
            tick     <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            if (ld_mil)
                presc <= '0;
            else if (run)
                presc <= adv ? '0 : presc + DIV_W'(1);

            if (ld_mil)
                mil <= time_in;
            else if (adv)
                mil <= bcd_inc(mil, 8'h99);

            if (ld_second)
                second <= time_in;
            else if (c_second)
                second <= bcd_inc(second, 8'h59);

            if (ld_minute)
                minute <= time_in;
            else if (c_minute)
                minute <= bcd_inc(minute, 8'h59);

            if (ld_hour)
                hour <= time_in;
            else if (c_hour)
                hour <= bcd_inc(hour, 8'h23);

            tick     <= adv;
            day_wrap <= wrap;
            set_err  <= bad_load;
        end
    end

    // 13..19 -> 01..07 and 20..23 -> 08..11, done per digit to stay in BCD.
    always_comb begin
        hour_disp = hour;
        if (mode_12h) begin
            if (hour == 8'h00)
                hour_disp = 8'h12;
            else if ((hour[7:4] == 4'd1) && (hour[3:0] >= 4'd3))
                hour_disp = {4'd0, hour[3:0] - 4'd2};
            else if (hour[7:4] == 4'd2)
                hour_disp = (hour[3:0] <= 4'd1) ? {4'd0, hour[3:0] + 4'd8}
                                                : {4'd1, hour[3:0] - 4'd2};
        end
    end

    assign pm       = (hour >= 8'h12);
    assign time_bcd = {hour_disp, minute, second, mil};

endmodule

// File: tb/tb_bcd_rtc_counter.sv
// Bench for bcd_rtc_counter: a hundredths-count time model pushes the expected
// time on every model tick; each DUT tick pops and compares.
module tb_bcd_rtc_counter;
    localparam int DIV = 4;
    localparam int DAY = 8640000;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mode_12h;
    logic [7:0]  time_in;
    logic        set_hour, set_minute, set_second, set_mil;
    logic [31:0] time_bcd;
    logic        pm, tick, day_wrap, set_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int m_presc   = 0;
    int m_t       = 0;
    bit m_tick    = 1'b0;
    logic [31:0] sb[$];
    logic [31:0] exp_t;

    bcd_rtc_counter #(.CLK_DIV(DIV), .DIV_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .time_in(time_in),
        .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
        .set_mil(set_mil), .time_bcd(time_bcd), .pm(pm), .tick(tick),
        .day_wrap(day_wrap), .set_err(set_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] b8(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int bi(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [31:0] t2bcd(input int t);
        return {b8(t / 360000), b8((t / 6000) % 60), b8((t / 100) % 60), b8(t % 100)};
    endfunction

    function automatic int with_hour(input int t, input int h);
        return h * 360000 + (t % 360000);
    endfunction
    function automatic int with_min(input int t, input int mi);
        return (t / 360000) * 360000 + mi * 6000 + (t % 6000);
    endfunction
    function automatic int with_sec(input int t, input int s);
        return (t / 6000) * 6000 + s * 100 + (t % 100);
    endfunction
    function automatic int with_mil(input int t, input int c);
        return (t / 100) * 100 + c;
    endfunction

    // One clock edge; the model advances from the inputs held across the edge.
    task automatic cyc();
        @(posedge clk);
        m_tick = 1'b0;
        if (rst) begin
            m_presc = 0;
            m_t     = 0;
        end else begin
            if (run) begin
                if (m_presc == DIV - 1) begin
                    m_presc = 0;
                    m_tick  = 1'b1;
                end else begin
                    m_presc++;
                end
            end
            if (set_mil) m_presc = 0;
            if (m_tick && !(set_hour || set_minute || set_second || set_mil)) begin
                m_t = (m_t + 1) % DAY;
                sb.push_back(t2bcd(m_t));
            end
        end
        #1;
    endtask

    task automatic load(input logic [3:0] mask, input logic [7:0] v);
        time_in = v;
        {set_hour, set_minute, set_second, set_mil} = mask;
        cyc();
        {set_hour, set_minute, set_second, set_mil} = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mode_12h = 1'b0; time_in = 8'h00;
        {set_hour, set_minute, set_second, set_mil} = 4'b0000;
        cyc(); cyc();
        total_cnt++; if (time_bcd !== 32'h0) $display("FAIL reset_time got %h exp %h", time_bcd, 32'h0); else pass_cnt++;
        total_cnt++; if (pm !== 1'b0) $display("FAIL reset_pm got %b exp 0", pm); else pass_cnt++;
        total_cnt++; if (tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", tick); else pass_cnt++;
        total_cnt++; if (day_wrap !== 1'b0) $display("FAIL reset_wrap got %b exp 0", day_wrap); else pass_cnt++;
        total_cnt++; if (set_err !== 1'b0) $display("FAIL reset_err got %b exp 0", set_err); else pass_cnt++;
        rst = 1'b0; run = 1'b1;
        for (int i = 0; i < 42; i++) begin
            cyc();
            total_cnt++; if (tick !== m_tick) $display("FAIL pre_tick cyc %0d got %b exp %b", i, tick, m_tick); else pass_cnt++;
            if (tick === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL pre_sb unexpected tick time %h", time_bcd);
                else begin
                    exp_t = sb.pop_front();
                    if (time_bcd !== exp_t) $display("FAIL pre_time got %h exp %h", time_bcd, exp_t); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (time_bcd !== 32'h00000010) $display("FAIL pre_count got %h exp %h", time_bcd, 32'h00000010); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (time_bcd !== 32'h0) $display("FAIL async_rst got %h exp %h", time_bcd, 32'h0); else pass_cnt++;
        total_cnt++; if (tick !== 1'b0) $display("FAIL async_tick got %b exp 0", tick); else pass_cnt++;
        cyc();
    endtask

    task automatic test_count();
        int seen = 0;
        rst = 1'b0; run = 1'b1;
        for (int i = 0; i < 100 * DIV; i++) begin
            cyc();
            total_cnt++; if (tick !== m_tick) $display("FAIL cnt_tick cyc %0d got %b exp %b", i, tick, m_tick); else pass_cnt++;
            if (tick === 1'b1) begin
                seen++;
                total_cnt++;
                if (sb.size() == 0) $display("FAIL cnt_sb unexpected tick time %h", time_bcd);
                else begin
                    exp_t = sb.pop_front();
                    if (time_bcd !== exp_t) $display("FAIL cnt_time got %h exp %h", time_bcd, exp_t); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (seen !== 100) $display("FAIL cnt_ticks got %0d exp 100", seen); else pass_cnt++;
        total_cnt++; if (time_bcd !== 32'h00000100) $display("FAIL cnt_final got %h exp %h", time_bcd, 32'h00000100); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit got = 1'b0;
        run = 1'b0;
        load(4'b1000, 8'h23); load(4'b0100, 8'h59); load(4'b0010, 8'h59); load(4'b0001, 8'h99);
        m_t = DAY - 1;
        total_cnt++; if (time_bcd !== 32'h23595999) $display("FAIL wrap_load got %h exp %h", time_bcd, 32'h23595999); else pass_cnt++;
        total_cnt++; if (pm !== 1'b1) $display("FAIL wrap_pm_before got %b exp 1", pm); else pass_cnt++;
        run = 1'b1;
        for (int i = 0; i < 3 * DIV && !got; i++) begin
            cyc();
            total_cnt++; if (tick !== m_tick) $display("FAIL wrap_tick cyc %0d got %b exp %b", i, tick, m_tick); else pass_cnt++;
            if (tick === 1'b1) begin
                got = 1'b1;
                total_cnt++;
                if (sb.size() == 0) $display("FAIL wrap_sb unexpected tick time %h", time_bcd);
                else begin
                    exp_t = sb.pop_front();
                    if (time_bcd !== exp_t) $display("FAIL wrap_time got %h exp %h", time_bcd, exp_t); else pass_cnt++;
                end
                total_cnt++; if (day_wrap !== 1'b1) $display("FAIL wrap_pulse got %b exp 1", day_wrap); else pass_cnt++;
                total_cnt++; if (pm !== 1'b0) $display("FAIL wrap_pm_after got %b exp 0", pm); else pass_cnt++;
            end else begin
                total_cnt++; if (day_wrap !== 1'b0) $display("FAIL wrap_early got %b exp 0", day_wrap); else pass_cnt++;
            end
        end
        total_cnt++; if (!got) $display("FAIL wrap_timeout got no tick exp tick within %0d cycles", 3 * DIV); else pass_cnt++;
        cyc();
        total_cnt++; if (day_wrap !== 1'b0) $display("FAIL wrap_one_cycle got %b exp 0", day_wrap); else pass_cnt++;
        run = 1'b0;
    endtask

    task automatic test_12h();
        logic [7:0] ld[4]    = '{8'h00, 8'h12, 8'h23, 8'h13};
        logic [7:0] exp_h[4] = '{8'h12, 8'h12, 8'h11, 8'h01};
        logic       exp_pm[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode_12h = 1'b1;
            load(4'b1000, ld[i]);
            m_t = with_hour(m_t, bi(ld[i]));
            total_cnt++; if (time_bcd[31:24] !== exp_h[i]) $display("FAIL h12_hour load %h got %h exp %h", ld[i], time_bcd[31:24], exp_h[i]); else pass_cnt++;
            total_cnt++; if (pm !== exp_pm[i]) $display("FAIL h12_pm load %h got %b exp %b", ld[i], pm, exp_pm[i]); else pass_cnt++;
        end
        mode_12h = 1'b0;
        #1;
        total_cnt++; if (time_bcd[31:24] !== 8'h13) $display("FAIL h24_hour got %h exp %h", time_bcd[31:24], 8'h13); else pass_cnt++;
        total_cnt++; if (time_bcd !== t2bcd(m_t)) $display("FAIL h24_time got %h exp %h", time_bcd, t2bcd(m_t)); else pass_cnt++;
        mode_12h = 1'b1;
        #1;
        total_cnt++; if (time_bcd[31:24] !== 8'h01) $display("FAIL h12_comb got %h exp %h", time_bcd[31:24], 8'h01); else pass_cnt++;
        mode_12h = 1'b0;
    endtask

    task automatic test_illegal();
        run = 1'b0;
        load(4'b0100, 8'h60);
        total_cnt++; if (set_err !== 1'b1) $display("FAIL ill_min_err got %b exp 1", set_err); else pass_cnt++;
        total_cnt++; if (time_bcd !== t2bcd(m_t)) $display("FAIL ill_min_time got %h exp %h", time_bcd, t2bcd(m_t)); else pass_cnt++;
        cyc();
        total_cnt++; if (set_err !== 1'b0) $display("FAIL ill_min_once got %b exp 0", set_err); else pass_cnt++;
        load(4'b1000, 8'h1A);
        total_cnt++; if (set_err !== 1'b1) $display("FAIL ill_hour_err got %b exp 1", set_err); else pass_cnt++;
        total_cnt++; if (time_bcd !== t2bcd(m_t)) $display("FAIL ill_hour_time got %h exp %h", time_bcd, t2bcd(m_t)); else pass_cnt++;
        cyc();
        total_cnt++; if (set_err !== 1'b0) $display("FAIL ill_hour_once got %b exp 0", set_err); else pass_cnt++;
        // time_in is shared: 45 is a legal second but an illegal hour
        load(4'b1010, 8'h45);
        m_t = with_sec(m_t, 45);
        total_cnt++; if (time_bcd !== t2bcd(m_t)) $display("FAIL ill_mix_time got %h exp %h", time_bcd, t2bcd(m_t)); else pass_cnt++;
        total_cnt++; if (set_err !== 1'b1) $display("FAIL ill_mix_err got %b exp 1", set_err); else pass_cnt++;
        cyc();
        total_cnt++; if (set_err !== 1'b0) $display("FAIL ill_mix_once got %b exp 0", set_err); else pass_cnt++;
    endtask

    task automatic test_collision();
        bit got = 1'b0;
        int n = 0;
        run = 1'b0;
        load(4'b1000, 8'h00); load(4'b0100, 8'h00); load(4'b0010, 8'h59); load(4'b0001, 8'h99);
        m_t = 5999;
        run = 1'b1;
        for (int i = 0; i < DIV - 1; i++) begin
            cyc();
            total_cnt++; if (tick !== 1'b0) $display("FAIL col_pre_tick cyc %0d got %b exp 0", i, tick); else pass_cnt++;
        end
        load(4'b0010, 8'h10);
        total_cnt++; if (tick !== 1'b1) $display("FAIL col_tick got %b exp 1", tick); else pass_cnt++;
        total_cnt++; if (time_bcd !== 32'h00001000) $display("FAIL col_time got %h exp %h", time_bcd, 32'h00001000); else pass_cnt++;
        m_t = with_sec(m_t, 10);
        m_t = with_mil(m_t, 0);
        cyc(); cyc();
        load(4'b0001, 8'h50);
        m_t = with_mil(m_t, 50);
        total_cnt++; if (time_bcd !== 32'h00001050) $display("FAIL mil_load got %h exp %h", time_bcd, 32'h00001050); else pass_cnt++;
        for (int i = 0; i < 3 * DIV && !got; i++) begin
            cyc();
            n++;
            if (tick === 1'b1) begin
                got = 1'b1;
                total_cnt++;
                if (sb.size() == 0) $display("FAIL mil_sb unexpected tick time %h", time_bcd);
                else begin
                    exp_t = sb.pop_front();
                    if (time_bcd !== exp_t) $display("FAIL mil_time got %h exp %h", time_bcd, exp_t); else pass_cnt++;
                end
                total_cnt++; if (time_bcd !== 32'h00001051) $display("FAIL mil_51 got %h exp %h", time_bcd, 32'h00001051); else pass_cnt++;
            end
        end
        total_cnt++; if (n !== DIV || !got) $display("FAIL mil_latency got %0d cycles (tick %b) exp %0d", n, got, DIV); else pass_cnt++;
    endtask

    task automatic test_run_gating();
        logic [31:0] held;
        int held_p;
        int n = 0;
        bit got = 1'b0;
        run = 1'b1;
        cyc(); cyc();
        held = time_bcd;
        held_p = m_presc;
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total_cnt++; if (tick !== 1'b0) $display("FAIL gate_tick cyc %0d got %b exp 0", i, tick); else pass_cnt++;
        end
        total_cnt++; if (time_bcd !== held) $display("FAIL gate_time got %h exp %h", time_bcd, held); else pass_cnt++;
        run = 1'b1;
        for (int i = 0; i < 3 * DIV && !got; i++) begin
            cyc();
            n++;
            if (tick === 1'b1) begin
                got = 1'b1;
                total_cnt++;
                if (sb.size() == 0) $display("FAIL gate_sb unexpected tick time %h", time_bcd);
                else begin
                    exp_t = sb.pop_front();
                    if (time_bcd !== exp_t) $display("FAIL gate_resume got %h exp %h", time_bcd, exp_t); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (n !== DIV - held_p || !got) $display("FAIL gate_latency got %0d cycles (tick %b) exp %0d", n, got, DIV - held_p); else pass_cnt++;
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_12h();
        test_illegal();
        test_collision();
        test_run_gating();
        total_cnt++; if (sb.size() != 0) $display("FAIL sb_leftover got %0d exp 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
